// File: rtl/trafficlight_monitor.sv
// trafficlight_monitor: passive checker of the trafficlight rgb stream.
// Enforces phase order, dwell limits and request-before-green; reports first error, error count and cycles.
module trafficlight_monitor #(
    parameter int MIN_DWELL = 4,
    parameter int MAX_DWELL = 16
) (
    input  logic       clk,
    input  logic       resn,
    input  logic [2:0] rgb,
    input  logic       btn,
    output logic [1:0] phase,
    output logic       req_pending,
    output logic       err,
    output logic [2:0] err_code,
    output logic [3:0] err_cnt,
    output logic [7:0] cycles
);
    localparam int DW = $clog2(MAX_DWELL + 2);
    localparam logic [DW-1:0] MIN_D = DW'(MIN_DWELL);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);
    localparam logic [DW-1:0] SAT_D = DW'(MAX_DWELL + 1);

    if (MIN_DWELL < 1 || MAX_DWELL < MIN_DWELL) begin : g_bad_params
        $error("trafficlight_monitor: need MAX_DWELL >= MIN_DWELL >= 1");
    end

    typedef enum logic [1:0] {RED = 2'd0, PRE = 2'd1, GREEN = 2'd2, POST = 2'd3} phase_e;
    typedef enum logic [2:0] {E_NONE, E_ILLEGAL, E_SEQ, E_UNREQ, E_SHORT, E_LONG} err_e;

    phase_e        phase_q, phase_d, dec;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          req_q, req_d, err_q, err_d;
    err_e          code_q, code_d, code_now;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    cyc_q, cyc_d;
    logic          illegal, moved, in_red, seq_e, unreq_e, short_e, long_e, any_e;

    always_comb begin
        illegal  = !(rgb == 3'b100 || rgb == 3'b010 || rgb == 3'b110);
        // 110 is ambiguous: it means PRE on the way up and POST on the way down
        dec      = rgb == 3'b100 ? RED : rgb == 3'b010 ? GREEN :
                   (phase_q == RED || phase_q == PRE) ? PRE : POST;
        moved    = !illegal && dec != phase_q;
        in_red   = phase_q == RED;
        seq_e    = moved && dec != phase_e'(phase_q + 2'd1);
        unreq_e  = moved && in_red && !req_q;
        short_e  = moved && !in_red && dwell_q < MIN_D;
        long_e   = !illegal && !moved && !in_red && dwell_q == MAX_D;
        any_e    = illegal | seq_e | unreq_e | short_e | long_e;
        code_now = illegal ? E_ILLEGAL : seq_e ? E_SEQ : unreq_e ? E_UNREQ :
                   short_e ? E_SHORT : long_e ? E_LONG : E_NONE;
        phase_d  = moved ? dec : phase_q;
        dwell_d  = moved ? DW'(1) : (!illegal && dwell_q != SAT_D) ? dwell_q + 1'b1 : dwell_q;
        req_d    = (moved && in_red) ? btn : (req_q | btn);
        err_d    = err_q | any_e;
        code_d   = (any_e && !err_q) ? code_now : code_q;
        cnt_d    = (any_e && cnt_q != 4'hf) ? cnt_q + 1'b1 : cnt_q;
        cyc_d    = (moved && phase_q == POST && dec == RED) ? cyc_q + 1'b1 : cyc_q;
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            phase_q <= RED;
            dwell_q <= DW'(1);
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= E_NONE;
            cnt_q   <= 4'd0;
            cyc_q   <= 8'd0;
        end else begin
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            req_q   <= req_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
        end
    end

    assign phase       = phase_q;
    assign req_pending = req_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign err_cnt     = cnt_q;
    assign cycles      = cyc_q;
endmodule

// File: tb/tb_trafficlight_monitor.sv
// tb_trafficlight_monitor: scoreboard bench; stimulus pushes model predictions, a monitor pops and compares.
module tb_trafficlight_monitor;
    localparam int MIN = 4;
    localparam int MAX = 16;

    logic       clk = 1'b0, resn = 1'b1, btn = 1'b0;
    logic [2:0] rgb = 3'b100;
    logic [1:0] phase;
    logic       req_pending, err;
    logic [2:0] err_code;
    logic [3:0] err_cnt;
    logic [7:0] cycles;

    trafficlight_monitor #(.MIN_DWELL(MIN), .MAX_DWELL(MAX)) dut (
        .clk(clk), .resn(resn), .rgb(rgb), .btn(btn), .phase(phase), .req_pending(req_pending),
        .err(err), .err_code(err_code), .err_cnt(err_cnt), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ph;
        logic       rq;
        logic       er;
        logic [2:0] ec;
        logic [3:0] cnt;
        logic [7:0] cy;
    } obs_t;

    obs_t q[$];
    obs_t exp_o, act_o;
    int   n_cmp = 0, n_bad = 0;
    logic [2:0] bad_codes [5] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7};

    // reference model: phase as 0..3, run length uncapped
    int m_phase, m_len, m_code, m_cnt, m_cyc;
    bit m_req;

    task automatic model_reset();
        m_phase = 0; m_len = 1; m_code = 0; m_cnt = 0; m_cyc = 0; m_req = 0;
    endtask

    task automatic mstep(input logic [2:0] r, input logic b);
        bit ill, seq, unr, sho, lng;
        int d, code;
        obs_t e;
        seq = 0; unr = 0; sho = 0; lng = 0;
        ill = !(r == 3'b100 || r == 3'b010 || r == 3'b110);
        if (ill) begin
            m_req = m_req | b;
        end else begin
            d = (r == 3'b100) ? 0 : (r == 3'b010) ? 2 : (m_phase < 2) ? 1 : 3;
            if (d != m_phase) begin
                seq = d != (m_phase + 1) % 4;
                unr = (m_phase == 0) && !m_req;
                sho = (m_phase != 0) && (m_len < MIN);
                if (m_phase == 3 && d == 0) m_cyc = (m_cyc + 1) % 256;
                m_req = (m_phase == 0) ? b : (m_req | b);
                m_phase = d;
                m_len = 1;
            end else begin
                m_len++;
                lng = (m_phase != 0) && (m_len == MAX + 1);
                m_req = m_req | b;
            end
        end
        code = ill ? 1 : seq ? 2 : unr ? 3 : sho ? 4 : lng ? 5 : 0;
        if (code != 0) begin
            if (m_code == 0) m_code = code;
            if (m_cnt < 15) m_cnt++;
        end
        e.ph = 2'(m_phase); e.rq = m_req; e.er = m_code != 0; e.ec = 3'(m_code);
        e.cnt = 4'(m_cnt); e.cy = 8'(m_cyc);
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (resn && q.size() > 0) begin
            exp_o = q.pop_front();
            act_o = {phase, req_pending, err, err_code, err_cnt, cycles};
            n_cmp++;
            if (act_o !== exp_o) begin
                n_bad++;
                $display("FAIL sb t=%0t got ph=%0d rq=%0d er=%0d ec=%0d cnt=%0d cy=%0d want ph=%0d rq=%0d er=%0d ec=%0d cnt=%0d cy=%0d",
                         $time, act_o.ph, act_o.rq, act_o.er, act_o.ec, act_o.cnt, act_o.cy,
                         exp_o.ph, exp_o.rq, exp_o.er, exp_o.ec, exp_o.cnt, exp_o.cy);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, want);
        end
    endtask

    task automatic step(input logic [2:0] r, input logic b);
        @(negedge clk);
        rgb = r;
        btn = b;
        mstep(r, b);
    endtask

    task automatic run(input logic [2:0] r, input logic b, input int n);
        repeat (n) step(r, b);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // reset lands between clock edges so the clear must be asynchronous
    task automatic do_reset();
        @(posedge clk);
        #3;
        resn = 1'b0;
        rgb = 3'b100;
        btn = 1'b0;
        #1;
        chk("rst_phase", phase, 0);
        chk("rst_req", req_pending, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_queue", q.size(), 0);
        q.delete();
        model_reset();
        @(negedge clk);
        resn = 1'b1;
        mstep(3'b100, 1'b0);
    endtask

    function automatic logic [2:0] code_of(input int p);
        return p == 0 ? 3'b100 : p == 2 ? 3'b010 : 3'b110;
    endfunction

    task automatic rand_run(input int segs);
        int p, n;
        logic [2:0] r;
        p = 0;
        for (int s = 0; s < segs; s++) begin
            n = (p == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(2, 19));
            for (int i = 0; i < n; i++) begin
                r = code_of(p);
                if ($urandom_range(0, 39) == 0) r = bad_codes[$urandom_range(0, 4)];
                step(r, $urandom_range(0, 5) == 0);
            end
            p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : (p + 1) % 4;
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        run(3'b100, 1'b0, 50);
        step(3'b100, 1'b1);
        run(3'b100, 1'b0, 9);
        run(3'b110, 1'b0, 10);
        run(3'b010, 1'b0, 10);
        run(3'b110, 1'b0, 10);
        run(3'b100, 1'b0, 2);
        settle();
        chk("legal_cycles", cycles, 1);
        chk("legal_err", err, 0);
        do_reset();
        run(3'b100, 1'b0, 3);
        run(3'b110, 1'b0, 2);
        settle();
        chk("unreq_code", err_code, 3);
        do_reset();
        step(3'b100, 1'b1);
        run(3'b100, 1'b0, 3);
        run(3'b010, 1'b0, 5);
        run(3'b110, 1'b0, 5);
        run(3'b100, 1'b0, 2);
        settle();
        chk("seq_cycles", cycles, 1);
        chk("seq_cnt", err_cnt, 1);
        chk("seq_code", err_code, 2);
        do_reset();
        step(3'b100, 1'b1);
        run(3'b100, 1'b0, 3);
        run(3'b110, 1'b0, 5);
        run(3'b010, 1'b0, 3);
        run(3'b110, 1'b0, 5);
        run(3'b100, 1'b0, 3);
        step(3'b100, 1'b1);
        run(3'b100, 1'b0, 3);
        run(3'b110, 1'b0, 5);
        run(3'b010, 1'b0, 17);
        run(3'b110, 1'b0, 5);
        run(3'b100, 1'b0, 2);
        settle();
        chk("dwell_code", err_code, 4);
        chk("dwell_cnt", err_cnt, 2);
        do_reset();
        step(3'b100, 1'b1);
        run(3'b100, 1'b0, 3);
        run(3'b110, 1'b0, 5);
        run(3'b010, 1'b0, 5);
        step(3'b101, 1'b0);
        run(3'b010, 1'b0, 2);
        settle();
        chk("illegal_code", err_code, 1);
        chk("illegal_phase", phase, 2);
        for (int k = 0; k < 4; k++) begin
            do_reset();
            rand_run(12);
        end
        settle();
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
